// File: rtl/input_debounce_pkg.sv
// Shared constants and helpers for the input debounce block.
package input_debounce_pkg;

    localparam int unsigned DEBOUNCE_CLK_HZ         = 50_000_000;
    localparam int unsigned DEBOUNCE_PRESCALE_1MS   = DEBOUNCE_CLK_HZ / 1000;
    localparam int unsigned DEBOUNCE_STABLE_DEFAULT = 4;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, stability counter, registered level and change strobe.
module debounce_channel
    import input_debounce_pkg::*;
#(
    parameter int unsigned STABLE = DEBOUNCE_STABLE_DEFAULT
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Enable,
    input  logic tick,
    input  logic In,
    output logic Out,
    output logic Changed
);

    localparam int unsigned CW = clog2(STABLE + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          out_q;
    logic          out_d;
    logic          chg_q;
    logic          chg_d;

    // A tick that agrees with the current level restarts the count, rejecting glitches.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        chg_d = 1'b0;
        if (!Enable) begin
            cnt_d = '0;
        end else if (tick) begin
            if (sync2_q == out_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE - 1)) begin
                out_d = sync2_q;
                cnt_d = '0;
                chg_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= In;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            chg_q   <= chg_d;
        end
    end

    assign Out     = out_q;
    assign Changed = chg_q;

endmodule

// File: rtl/input_debounce.sv
// Multi-channel input conditioner: shared sample-tick prescaler feeding per-channel debounce lanes.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned STABLE   = DEBOUNCE_STABLE_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic [WIDTH-1:0] In,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] Changed
);

    localparam int unsigned PW = clog2(PRESCALE);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_c;

    assign tick_c = (presc_q == PW'(PRESCALE - 1));

    // Prescaler is held at zero while disabled so the first tick lands PRESCALE cycles after enable.
    always_comb begin
        presc_d = presc_q;
        if (!Enable || tick_c) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_ch
        debounce_channel #(
            .STABLE (STABLE)
        ) u_ch (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .Enable  (Enable),
            .tick    (tick_c),
            .In      (In[g]),
            .Out     (Out[g]),
            .Changed (Changed[g])
        );
    end

endmodule

// File: tb/tb_input_debounce.sv
// Directed self-checking bench for input_debounce with WIDTH=4, PRESCALE=4, STABLE=3.
module tb_input_debounce;

    logic       Clk;
    logic       Reset_n;
    logic       Enable;
    logic [3:0] In;
    logic [3:0] Out;
    logic [3:0] Changed;

    logic       clk_en = 1'b1;
    int         n_checks = 0;
    int         n_fail = 0;

    int         viol = 0;
    int         chg3_cnt = 0;
    int         rise3_cnt = 0;
    logic [3:0] prev_out = 4'h0;

    input_debounce #(
        .WIDTH    (4),
        .PRESCALE (4),
        .STABLE   (3)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Enable  (Enable),
        .In      (In),
        .Out     (Out),
        .Changed (Changed)
    );

    initial begin
        Clk = 1'b0;
        forever begin
            #5;
            if (clk_en) Clk = ~Clk;
        end
    end

    // Changed must equal the per-bit change of Out between consecutive samples.
    always @(negedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_out <= 4'h0;
        end else begin
            if (Changed !== (Out ^ prev_out)) viol <= viol + 1;
            if (Changed[3]) chg3_cnt <= chg3_cnt + 1;
            if (Out[3] && !prev_out[3]) rise3_cnt <= rise3_cnt + 1;
            prev_out <= Out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic wait_out(input logic [3:0] mask, input logic [3:0] val, input int maxe, output int n);
        n = 0;
        while (((Out & mask) != val) && (n < maxe)) begin
            @(negedge Clk);
            n++;
        end
    endtask

    int         n;
    int         base_chg;
    int         base_rise;
    logic [3:0] acc_out;
    logic [3:0] acc_chg;

    initial begin
        Reset_n = 1'b1;
        Enable  = 1'b1;
        In      = 4'hF;

        // Power-up with all pins high
        #2 Reset_n = 1'b0;
        #1;
        check("rst_out", 32'(Out), 32'h0);
        check("rst_chg", 32'(Changed), 32'h0);
        step();
        step();
        Reset_n = 1'b1;
        wait_out(4'hF, 4'hF, 20, n);
        check("pu_lat", 32'(n), 32'd12);
        check("pu_chg", 32'(Changed), 32'hF);
        step();
        check("pu_chg_clr", 32'(Changed), 32'h0);
        check("pu_out", 32'(Out), 32'hF);

        // All pins low again
        In = 4'h0;
        wait_out(4'hF, 4'h0, 20, n);
        check("fall_lat_ok", 32'(n >= 11 && n <= 14), 32'd1);
        check("fall_chg", 32'(Changed), 32'hF);

        // Glitch on bit 0 for 5 cycles
        acc_out = 4'h0;
        acc_chg = 4'h0;
        In = 4'h1;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) In = 4'h0;
            step();
            acc_out |= Out;
            acc_chg |= Changed;
        end
        check("glitch_out", 32'(acc_out), 32'h0);
        check("glitch_chg", 32'(acc_chg), 32'h0);
        In = 4'h1;
        wait_out(4'h1, 4'h1, 20, n);
        check("post_glitch_lat_ok", 32'(n >= 11 && n <= 14), 32'd1);
        check("post_glitch_chg", 32'(Changed), 32'h1);

        // Simultaneous rise on bits 1 and 2
        In = 4'h7;
        wait_out(4'h6, 4'h6, 20, n);
        check("dual_lat_ok", 32'(n >= 11 && n <= 14), 32'd1);
        check("dual_out", 32'(Out), 32'h7);
        check("dual_chg", 32'(Changed), 32'h6);
        In = 4'h5;
        wait_out(4'h2, 4'h0, 20, n);
        check("b1_fall_lat_ok", 32'(n >= 11 && n <= 14), 32'd1);
        check("b1_fall_out", 32'(Out), 32'h5);
        check("b1_fall_chg", 32'(Changed), 32'h2);

        // Enable dropped after two ticks of disagreement on bit 3
        Enable = 1'b0;
        step();
        Enable = 1'b1;
        In = 4'hD;
        repeat (9) step();
        Enable = 1'b0;
        acc_out = 4'h0;
        acc_chg = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            acc_out |= Out;
            acc_chg |= Changed;
        end
        check("en_hold_out", 32'(acc_out), 32'h5);
        check("en_hold_chg", 32'(acc_chg), 32'h0);
        Enable = 1'b1;
        wait_out(4'h8, 4'h8, 30, n);
        check("en_resume_lat", 32'(n), 32'd12);
        check("en_resume_chg", 32'(Changed), 32'h8);

        // Reset with the clock stopped
        In = 4'h5;
        wait_out(4'h8, 4'h0, 20, n);
        check("b3_fall_lat_ok", 32'(n >= 11 && n <= 14), 32'd1);
        step();
        check("pre_rst_out", 32'(Out), 32'h5);
        clk_en = 1'b0;
        #22 Reset_n = 1'b0;
        #1;
        check("stop_rst_out", 32'(Out), 32'h0);
        check("stop_rst_chg", 32'(Changed), 32'h0);
        #10 Reset_n = 1'b1;
        #1 clk_en = 1'b1;
        wait_out(4'hF, 4'h5, 20, n);
        check("rst_rel_lat", 32'(n), 32'd12);
        check("rst_rel_chg", 32'(Changed), 32'h5);

        // Bounce train on bit 3, then a steady high
        step();
        base_chg  = chg3_cnt;
        base_rise = rise3_cnt;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) In[3] = ~In[3];
            step();
        end
        In[3] = 1'b1;
        repeat (20) step();
        check("bounce_out", 32'(Out), 32'hD);
        check("bounce_chg_cnt", 32'(chg3_cnt - base_chg), 32'd1);
        check("bounce_rise_cnt", 32'(rise3_cnt - base_rise), 32'd1);

        check("chg_consistency", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
